// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register between two stages: valid/ready handshake, flush and bubble masking.
// SKID=1 uses a two-entry skid buffer so in_ready is a flop; SKID=0 is a single register.
module pipe_stage_skid #(
  parameter int DATA_W     = 149,
  parameter int CTRL_W     = 9,
  parameter int SKID       = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  generate
    if (SKID != 0) begin : g_skid
      state_t            state, state_n;
      logic              rdy_q;
      logic [DATA_W-1:0] head_data, skid_data;
      logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
      logic              push, pop, load_head, load_skid, shift;

      assign push = in_valid & rdy_q;
      assign pop  = (state != EMPTY) & out_ready;

      always_comb begin
        state_n   = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        case (state)
          EMPTY: if (push) begin
            state_n   = ONE;
            load_head = 1'b1;
          end
          ONE: begin
            if (push && !pop) begin
              state_n   = TWO;
              load_skid = 1'b1;
            end else if (pop && !push) begin
              state_n = EMPTY;
            end else if (push && pop) begin
              load_head = 1'b1;
            end
          end
          TWO: if (pop) begin
            state_n = ONE;
            shift   = 1'b1;
          end
          default: state_n = EMPTY;
        endcase
        // Flush overrides everything, including a push presented in the same cycle.
        if (flush) begin
          state_n   = EMPTY;
          load_head = 1'b0;
          load_skid = 1'b0;
          shift     = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          state <= state_n;
          rdy_q <= (state_n != TWO);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          head_data <= '0;
          head_ctrl <= '0;
          skid_data <= '0;
          skid_ctrl <= '0;
        end else if (flush) begin
          head_ctrl <= '0;
          skid_ctrl <= '0;
          if (FLUSH_DATA != 0) begin
            head_data <= '0;
            skid_data <= '0;
          end
        end else begin
          if (load_head) begin
            head_data <= in_data;
            head_ctrl <= in_ctrl;
          end
          if (load_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end
          if (shift) begin
            head_data <= skid_data;
            head_ctrl <= skid_ctrl;
          end
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);
      assign out_data  = head_data;
      assign out_ctrl  = (state != EMPTY) ? head_ctrl : '0;
      assign occupancy = (state == TWO) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);
    end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] head_data;
      logic [CTRL_W-1:0] head_ctrl;
      logic              push, pop;

      assign in_ready = ~valid_q | out_ready;
      assign push     = in_valid & in_ready;
      assign pop      = valid_q & out_ready;

      // A push together with a pop simply overwrites the head, giving one entry per cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q   <= 1'b0;
          head_data <= '0;
          head_ctrl <= '0;
        end else if (flush) begin
          valid_q   <= 1'b0;
          head_ctrl <= '0;
          if (FLUSH_DATA != 0) head_data <= '0;
        end else if (push) begin
          valid_q   <= 1'b1;
          head_data <= in_data;
          head_ctrl <= in_ctrl;
        end else if (pop) begin
          valid_q <= 1'b0;
        end
      end

      assign out_valid = valid_q;
      assign out_data  = head_data;
      assign out_ctrl  = valid_q ? head_ctrl : '0;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share the same inputs.
// Directed scenarios plus a random run against queue-based models of each variant.
module tb_pipe_stage_skid;
  localparam int DW = 149;
  localparam int CW = 9;

  logic          clk, rst, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;

  logic          r1_in_ready, r1_out_valid, r0_in_ready, r0_out_valid;
  logic [DW-1:0] r1_out_data, r0_out_data;
  logic [CW-1:0] r1_out_ctrl, r0_out_ctrl;
  logic [1:0]    r1_occ, r0_occ;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .FLUSH_DATA(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(r1_out_valid), .out_ready(out_ready), .out_data(r1_out_data),
    .out_ctrl(r1_out_ctrl), .occupancy(r1_occ));

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .FLUSH_DATA(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(r0_out_valid), .out_ready(out_ready), .out_data(r0_out_data),
    .out_ctrl(r0_out_ctrl), .occupancy(r0_occ));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid1 got %b exp 0", r1_out_valid); end
    checks++; if (r1_out_ctrl !== '0) begin errors++; $display("[TB] FAIL reset_ctrl1 got %h exp 0", r1_out_ctrl); end
    checks++; if (r1_out_data !== '0) begin errors++; $display("[TB] FAIL reset_data1 got %h exp 0", r1_out_data); end
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready1 got %b exp 1", r1_in_ready); end
    checks++; if (r1_occ !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ1 got %0d exp 0", r1_occ); end
    checks++; if (r0_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid0 got %b exp 0", r0_out_valid); end
    checks++; if (r0_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready0 got %b exp 1", r0_in_ready); end
    checks++; if (r0_occ !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ0 got %0d exp 0", r0_occ); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i > 1) begin
        checks++; if (r1_out_valid !== 1'b1 || r1_out_data !== DW'(i-1)) begin errors++; $display("[TB] FAIL stream_data1 got %h exp %h", r1_out_data, i-1); end
        checks++; if (r1_occ !== 2'd1) begin errors++; $display("[TB] FAIL stream_occ1 got %0d exp 1", r1_occ); end
        checks++; if (r0_out_valid !== 1'b1 || r0_out_data !== DW'(i-1)) begin errors++; $display("[TB] FAIL stream_data0 got %h exp %h", r0_out_data, i-1); end
      end
      in_data = DW'(i); in_ctrl = CW'(i);
      if (i == 9) in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b0 || r1_occ !== 2'd0) begin errors++; $display("[TB] FAIL stream_drain1 got valid %b occ %0d exp 0 0", r1_out_valid, r1_occ); end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = DW'('hA);
    @(negedge clk); in_data = DW'('hB);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (r1_occ !== 2'd2) begin errors++; $display("[TB] FAIL skid_occ got %0d exp 2", r1_occ); end
    checks++; if (r1_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL skid_ready_full got %b exp 0", r1_in_ready); end
    checks++; if (r1_out_data !== DW'('hA)) begin errors++; $display("[TB] FAIL skid_first got %h exp a", r1_out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b1 || r1_out_data !== DW'('hB)) begin errors++; $display("[TB] FAIL skid_second got %h exp b", r1_out_data); end
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL skid_ready_after_pop got %b exp 1", r1_in_ready); end
    @(negedge clk);
    checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL skid_empty got %b exp 0", r1_out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = DW'('hA); in_ctrl = 9'h1FF;
    @(negedge clk); in_data = DW'('hB);
    @(negedge clk);
    checks++; if (r1_occ !== 2'd2) begin errors++; $display("[TB] FAIL flush_pre_occ got %0d exp 2", r1_occ); end
    flush = 1'b1; in_data = DW'('hC);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (r1_out_valid !== 1'b0 || r1_out_ctrl !== '0 || r1_occ !== 2'd0) begin errors++; $display("[TB] FAIL flush_two got valid %b ctrl %h occ %0d exp 0 0 0", r1_out_valid, r1_out_ctrl, r1_occ); end
    checks++; if (r0_out_valid !== 1'b0 || r0_out_ctrl !== '0) begin errors++; $display("[TB] FAIL flush_single got valid %b ctrl %h exp 0 0", r0_out_valid, r0_out_ctrl); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (r1_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_c got valid %b data %h exp 0", r1_out_valid, r1_out_data); end
    end
    // Flush while one entry is held: in_ready stays 1 but the push must vanish.
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'('hA);
    @(negedge clk); flush = 1'b1; in_data = DW'('hC);
    checks++; if (r1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b exp 1", r1_in_ready); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    checks++; if (r1_out_valid !== 1'b0 || r1_occ !== 2'd0) begin errors++; $display("[TB] FAIL flush_one got valid %b occ %0d exp 0 0", r1_out_valid, r1_occ); end
  endtask

  task automatic test_ctrl_bubble();
    bit vseq[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    out_ready = 1'b1; in_ctrl = 9'h1FF;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++; if (r1_out_valid !== vseq[k-1] || r1_out_ctrl !== (vseq[k-1] ? 9'h1FF : 9'h000)) begin errors++; $display("[TB] FAIL bubble_ctrl got valid %b ctrl %h exp %b", r1_out_valid, r1_out_ctrl, vseq[k-1]); end
      end
      if (k < 4) in_valid = vseq[k];
    end
  endtask

  task automatic test_skid0();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = DW'('h5);
    @(negedge clk); in_data = DW'('h6);
    checks++; if (r0_out_valid !== 1'b1 || r0_out_data !== DW'('h5)) begin errors++; $display("[TB] FAIL single_head got %h exp 5", r0_out_data); end
    #1;
    checks++; if (r0_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready_stall got %b exp 0", r0_in_ready); end
    @(negedge clk);
    checks++; if (r0_out_data !== DW'('h5)) begin errors++; $display("[TB] FAIL single_hold got %h exp 5", r0_out_data); end
    out_ready = 1'b1;
    #1;
    checks++; if (r0_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready_go got %b exp 1", r0_in_ready); end
    @(negedge clk); in_valid = 1'b0;
    checks++; if (r0_out_valid !== 1'b1 || r0_out_data !== DW'('h6) || r0_occ !== 2'd1) begin errors++; $display("[TB] FAIL single_replace got %h occ %0d exp 6 1", r0_out_data, r0_occ); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_data = DW'('h1); in_ctrl = 9'h0FF;
    @(negedge clk); in_data = DW'('h2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (r1_out_valid !== 1'b0 || r1_occ !== 2'd0 || r1_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL async_rst1 got valid %b occ %0d ready %b exp 0 0 1", r1_out_valid, r1_occ, r1_in_ready); end
    checks++; if (r1_out_data !== '0 || r1_out_ctrl !== '0) begin errors++; $display("[TB] FAIL async_rst_data got %h ctrl %h exp 0 0", r1_out_data, r1_out_ctrl); end
    checks++; if (r0_out_valid !== 1'b0 || r0_out_data !== '0) begin errors++; $display("[TB] FAIL async_rst0 got valid %b data %h exp 0 0", r0_out_valid, r0_out_data); end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
  endtask

  // Models: plain FIFOs of {ctrl,data}; capacity 2 (ready = not full at cycle start) and capacity 1.
  task automatic test_random();
    logic [DW+CW-1:0] q1[$];
    logic [DW+CW-1:0] q0[$];
    logic [159:0]     w;
    bit               rdy1, rdy0, pop1, pop0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      checks++; if (r1_out_valid !== (q1.size() > 0) || r1_occ !== 2'(q1.size()) || r1_in_ready !== (q1.size() < 2)) begin errors++; $display("[TB] FAIL rand_state1 cyc %0d got v%b o%0d r%b exp o%0d", n, r1_out_valid, r1_occ, r1_in_ready, q1.size()); end
      checks++; if (r0_out_valid !== (q0.size() > 0) || r0_occ !== 2'(q0.size()) || r0_in_ready !== (q0.size() == 0 || out_ready)) begin errors++; $display("[TB] FAIL rand_state0 cyc %0d got v%b o%0d r%b exp o%0d", n, r0_out_valid, r0_occ, r0_in_ready, q0.size()); end
      if (q1.size() > 0) begin
        checks++; if ({r1_out_ctrl, r1_out_data} !== q1[0]) begin errors++; $display("[TB] FAIL rand_head1 cyc %0d got %h exp %h", n, {r1_out_ctrl, r1_out_data}, q1[0]); end
      end else begin
        checks++; if (r1_out_ctrl !== '0) begin errors++; $display("[TB] FAIL rand_bubble1 cyc %0d got %h exp 0", n, r1_out_ctrl); end
      end
      if (q0.size() > 0) begin
        checks++; if ({r0_out_ctrl, r0_out_data} !== q0[0]) begin errors++; $display("[TB] FAIL rand_head0 cyc %0d got %h exp %h", n, {r0_out_ctrl, r0_out_data}, q0[0]); end
      end else begin
        checks++; if (r0_out_ctrl !== '0) begin errors++; $display("[TB] FAIL rand_bubble0 cyc %0d got %h exp 0", n, r0_out_ctrl); end
      end
      w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      in_data   = w[DW-1:0];
      in_ctrl   = CW'($urandom());
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rdy1 = (q1.size() < 2);
      rdy0 = (q0.size() == 0) || out_ready;
      pop1 = (q1.size() > 0) && out_ready;
      pop0 = (q0.size() > 0) && out_ready;
      @(posedge clk);
      if (flush) begin
        q1.delete();
        q0.delete();
      end else begin
        if (pop1) void'(q1.pop_front());
        if (in_valid && rdy1) q1.push_back({in_ctrl, in_data});
        if (pop0) void'(q0.pop_front());
        if (in_valid && rdy0) q0.push_back({in_ctrl, in_data});
      end
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_ctrl_bubble();
    test_skid0();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
